// File: rtl/dcc_event_buffer_if.sv
// -----------------------------------------------------------------------------
// dcc_event_buffer_if
// Bundle of the event-capture write side, the HPS word-stream read side and
// the status/overflow signals of dcc_event_buffer.
//
// master : event source / HPS side (drives evt_*, rd_ack, ovf_clr)
// slave  : the buffer itself (drives evt_ready, rd_*, fill_level, ovf_count)
//
// Signals
//   evt_valid  event present on evt_* lines
//   evt_ready  buffer accepts an event this cycle
//   evt_pps    PPS count of the event (32)
//   evt_time   coarse time since PPS (TIME_W)
//   evt_data   NUM_CH channel words, ch k at [32k+31:32k]
//   rd_word    current word of the head record (32)
//   rd_valid   rd_word is valid
//   rd_sof     rd_word is word 0 of a record
//   rd_ack     HPS consumed rd_word
//   fill_level records stored, including the one being read
//   ovf_count  dropped events, saturating (16)
//   ovf_clr    clears ovf_count
// -----------------------------------------------------------------------------
interface dcc_event_buffer_if #(
    parameter int NUM_CH = 32,
    parameter int DEPTH  = 16,
    parameter int TIME_W = 26
);
    logic                      evt_valid;
    logic                      evt_ready;
    logic [31:0]               evt_pps;
    logic [TIME_W-1:0]         evt_time;
    logic [NUM_CH*32-1:0]      evt_data;
    logic [31:0]               rd_word;
    logic                      rd_valid;
    logic                      rd_sof;
    logic                      rd_ack;
    logic [$clog2(DEPTH):0]    fill_level;
    logic [15:0]               ovf_count;
    logic                      ovf_clr;

    modport master (
        output evt_valid, evt_pps, evt_time, evt_data, rd_ack, ovf_clr,
        input  evt_ready, rd_word, rd_valid, rd_sof, fill_level, ovf_count
    );

    modport slave (
        input  evt_valid, evt_pps, evt_time, evt_data, rd_ack, ovf_clr,
        output evt_ready, rd_word, rd_valid, rd_sof, fill_level, ovf_count
    );
endinterface

// File: rtl/dcc_event_buffer.sv
// -----------------------------------------------------------------------------
// dcc_event_buffer
// Event capture FIFO for the detector channel data path. Each accepted event
// (PPS count, coarse time, NUM_CH channel words) is stored atomically as one
// record in a DEPTH-entry FIFO. The HPS drains the head record one 32-bit word
// per acknowledge: w0 = PPS, w1 = zero-padded time, w2+k = channel k.
// Events arriving while the FIFO is full are dropped and counted.
//
// Ports
//   clk_clk        system clock, rising edge
//   reset_reset_n  synchronous active-low reset
//   bus            dcc_event_buffer_if.slave (event input, word stream,
//                  fill level, overflow counter and clear)
//
// Read FSM
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | nothing presented; waits for a stored record
//   ST_PRESENT | word r_idx of head record on rd_word, rd_valid high
// -----------------------------------------------------------------------------
module dcc_event_buffer #(
    parameter int NUM_CH = 32,
    parameter int DEPTH  = 16,
    parameter int TIME_W = 26
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    dcc_event_buffer_if.slave    bus
);

    localparam int NUM_WORDS = NUM_CH + 2;
    localparam int REC_W     = NUM_WORDS * 32;
    localparam int IDX_W     = $clog2(NUM_WORDS);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // One packed record per slot, w0 in the least significant word, so a push
    // writes the whole record in a single assignment.
    logic [REC_W-1:0]  r_mem [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_idx;
    logic [15:0]       r_ovf;
    state_t            r_state;

    state_t            w_state_next;
    logic [IDX_W-1:0]  w_idx_next;
    logic              w_ready;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_rd_valid;
    logic              w_rd_sof;
    logic [REC_W-1:0]  w_head;
    logic [31:0]       w_rd_word;

    // Readiness uses the pre-edge count, so a pop in the same cycle never
    // makes room for an incoming event.
    assign w_ready = reset_reset_n && (r_count < DEPTH_CNT);
    assign w_push  = bus.evt_valid && w_ready;
    assign w_drop  = bus.evt_valid && !w_ready;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_pop        = 1'b0;
        w_rd_valid   = 1'b0;
        w_rd_sof     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = ST_PRESENT;
                    w_idx_next   = '0;
                end
            end
            ST_PRESENT: begin
                w_rd_valid = 1'b1;
                w_rd_sof   = (r_idx == '0);
                if (bus.rd_ack) begin
                    if (r_idx == LAST_IDX) begin
                        w_pop      = 1'b1;
                        w_idx_next = '0;
                        // Count is at least one here; records remain if more
                        // than the head was stored or a push lands this edge.
                        if ((r_count != ONE_CNT) || w_push) begin
                            w_state_next = ST_PRESENT;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the counter at one.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_ovf <= '0;
        end else if (w_drop) begin
            if (bus.ovf_clr) begin
                r_ovf <= 16'd1;
            end else if (r_ovf != 16'hFFFF) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end else if (bus.ovf_clr) begin
            r_ovf <= '0;
        end
    end

    // Record storage carries no reset; stale slots are never presented
    // because the count gates the read side.
    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.evt_data, 32'(bus.evt_time), bus.evt_pps};
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_rd_word = '0;
        if (w_rd_valid) begin
            w_rd_word = w_head[{r_idx, 5'b00000} +: 32];
        end
    end

    assign bus.evt_ready  = w_ready;
    assign bus.rd_word    = w_rd_word;
    assign bus.rd_valid   = w_rd_valid;
    assign bus.rd_sof     = w_rd_sof;
    assign bus.fill_level = r_count;
    assign bus.ovf_count  = r_ovf;

endmodule

// File: tb/tb_dcc_event_buffer.sv
// -----------------------------------------------------------------------------
// tb_dcc_event_buffer
// Self-checking bench for dcc_event_buffer (NUM_CH=4, DEPTH=4, TIME_W=26).
// Inputs change on the falling edge; outputs are compared on the following
// falling edge against a record-queue reference model and, for the directed
// scenarios, against fixed expected values.
// -----------------------------------------------------------------------------
module tb_dcc_event_buffer;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int TIME_W = 26;
    localparam int NW     = NUM_CH + 2;

    typedef logic [NW-1:0][31:0] rec_t;

    typedef struct {
        string                 nm;
        bit                    v;
        logic [31:0]           pps;
        logic [TIME_W-1:0]     tm;
        logic [NUM_CH*32-1:0]  d;
        bit                    ack;
        bit                    clr;
        bit                    rn;
        bit                    e_valid;
        bit                    e_sof;
        logic [31:0]           e_word;
        int                    e_fill;
        bit                    e_ready;
        int                    e_ovf;
    } vec_t;

    logic clk_clk       = 1'b0;
    logic reset_reset_n = 1'b0;

    dcc_event_buffer_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TIME_W(TIME_W)) bus ();

    dcc_event_buffer #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TIME_W(TIME_W)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus)
    );

    always #5 clk_clk = ~clk_clk;

    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    rec_t m_q[$];
    int   m_idx  = 0;
    bit   m_pres = 1'b0;
    int   m_ovf  = 0;
    bit   m_rn   = 1'b0;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] pps, input logic [TIME_W-1:0] tm,
                                input logic [NUM_CH*32-1:0] d);
        rec_t r;
        r[0] = pps;
        r[1] = 32'(tm);
        for (int k = 0; k < NUM_CH; k++) r[2+k] = d[32*k +: 32];
        return r;
    endfunction

    function automatic logic [31:0] ev_pps(input int k);
        return 32'h100 + 32'(k);
    endfunction

    function automatic logic [TIME_W-1:0] ev_tm(input int k);
        return TIME_W'(k * 7 + 1);
    endfunction

    function automatic logic [NUM_CH*32-1:0] ev_d(input int k);
        logic [NUM_CH*32-1:0] d;
        for (int c = 0; c < NUM_CH; c++) d[32*c +: 32] = 32'hC000_0000 | (32'(k) << 8) | 32'(c);
        return d;
    endfunction

    // One clock edge of the buffer, described at record level.
    task automatic model_edge(input bit v, input rec_t rec, input bit ack, input bit clr, input bit rn);
        int pre;
        bit push, drop, pop;
        if (!rn) begin
            m_q.delete();
            m_idx  = 0;
            m_pres = 1'b0;
            m_ovf  = 0;
            return;
        end
        pre  = m_q.size();
        push = v && (pre < DEPTH);
        drop = v && (pre >= DEPTH);
        pop  = 1'b0;
        if (m_pres && ack) begin
            if (m_idx == NW - 1) begin
                pop   = 1'b1;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (drop) m_ovf = clr ? 1 : ((m_ovf < 65535) ? m_ovf + 1 : 65535);
        else if (clr) m_ovf = 0;
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back(rec);
        if (!m_pres) begin
            m_pres = (pre > 0);
            m_idx  = 0;
        end else if (pop) begin
            m_pres = (m_q.size() > 0);
        end
    endtask

    task automatic compare_model();
        rec_t  h;
        logic [31:0] w;
        w = 32'h0;
        if (m_pres) begin
            h = m_q[0];
            w = h[m_idx];
        end
        check("model.rd_valid",   32'(bus.rd_valid),   32'(m_pres));
        check("model.rd_sof",     32'(bus.rd_sof),     32'(m_pres && (m_idx == 0)));
        check("model.rd_word",    bus.rd_word,         w);
        check("model.fill_level", 32'(bus.fill_level), 32'(m_q.size()));
        check("model.evt_ready",  32'(bus.evt_ready),  32'(m_rn && (m_q.size() < DEPTH)));
        check("model.ovf_count",  32'(bus.ovf_count),  32'(m_ovf));
    endtask

    task automatic step(input bit v, input logic [31:0] pps, input logic [TIME_W-1:0] tm,
                        input logic [NUM_CH*32-1:0] d, input bit ack, input bit clr, input bit rn);
        bus.evt_valid = v;
        bus.evt_pps   = pps;
        bus.evt_time  = tm;
        bus.evt_data  = d;
        bus.rd_ack    = ack;
        bus.ovf_clr   = clr;
        reset_reset_n = rn;
        m_rn          = rn;
        @(posedge clk_clk);
        model_edge(v, mk(pps, tm, d), ack, clr, rn);
        @(negedge clk_clk);
        compare_model();
    endtask

    task automatic idle(input bit ack);
        step(1'b0, 32'h0, '0, '0, ack, 1'b0, 1'b1);
    endtask

    task automatic push_ev(input int k, input bit ack, input bit clr);
        step(1'b1, ev_pps(k), ev_tm(k), ev_d(k), ack, clr, 1'b1);
    endtask

    task automatic add(input string nm, input bit v, input logic [31:0] pps, input logic [TIME_W-1:0] tm,
                       input logic [NUM_CH*32-1:0] d, input bit ack, input bit rn,
                       input bit ev, input bit es, input logic [31:0] ew, input int ef,
                       input bit er, input int eo);
        vec_t t;
        t.nm = nm; t.v = v; t.pps = pps; t.tm = tm; t.d = d; t.ack = ack; t.clr = 1'b0; t.rn = rn;
        t.e_valid = ev; t.e_sof = es; t.e_word = ew; t.e_fill = ef; t.e_ready = er; t.e_ovf = eo;
        tbl.push_back(t);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NUM_CH*32-1:0] a_d;
        rec_t r;
        a_d = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

        // single event, then the fill/overflow sequence
        add("reset",   0, 0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 0);
        add("idle",    0, 0, 0, 0, 0, 1,  0, 0, 32'h0,        0, 1, 0);
        add("pushA",   1, 32'h10, 26'h3FFFFFF, a_d, 1, 1, 0, 0, 32'h0, 1, 1, 0);
        add("A.w0",    0, 0, 0, 0, 1, 1,  1, 1, 32'h10,       1, 1, 0);
        add("A.w1",    0, 0, 0, 0, 1, 1,  1, 0, 32'h03FFFFFF, 1, 1, 0);
        add("A.w2",    0, 0, 0, 0, 1, 1,  1, 0, 32'hA0,       1, 1, 0);
        add("A.w3",    0, 0, 0, 0, 1, 1,  1, 0, 32'hA1,       1, 1, 0);
        add("A.w4",    0, 0, 0, 0, 1, 1,  1, 0, 32'hA2,       1, 1, 0);
        add("A.w5",    0, 0, 0, 0, 1, 1,  1, 0, 32'hA3,       1, 1, 0);
        add("A.done",  0, 0, 0, 0, 1, 1,  0, 0, 32'h0,        0, 1, 0);
        add("fill1",   1, ev_pps(1), ev_tm(1), ev_d(1), 0, 1, 0, 0, 32'h0,     1, 1, 0);
        add("fill2",   1, ev_pps(2), ev_tm(2), ev_d(2), 0, 1, 1, 1, ev_pps(1), 2, 1, 0);
        add("fill3",   1, ev_pps(3), ev_tm(3), ev_d(3), 0, 1, 1, 1, ev_pps(1), 3, 1, 0);
        add("fill4",   1, ev_pps(4), ev_tm(4), ev_d(4), 0, 1, 1, 1, ev_pps(1), 4, 0, 0);
        add("drop5",   1, ev_pps(5), ev_tm(5), ev_d(5), 0, 1, 1, 1, ev_pps(1), 4, 0, 1);
        add("drop6",   1, ev_pps(6), ev_tm(6), ev_d(6), 0, 1, 1, 1, ev_pps(1), 4, 0, 2);

        bus.evt_valid = 1'b0;
        bus.evt_pps   = '0;
        bus.evt_time  = '0;
        bus.evt_data  = '0;
        bus.rd_ack    = 1'b0;
        bus.ovf_clr   = 1'b0;
        @(negedge clk_clk);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].pps, tbl[i].tm, tbl[i].d, tbl[i].ack, tbl[i].clr, tbl[i].rn);
            check({tbl[i].nm, ".rd_valid"},   32'(bus.rd_valid),   32'(tbl[i].e_valid));
            check({tbl[i].nm, ".rd_sof"},     32'(bus.rd_sof),     32'(tbl[i].e_sof));
            check({tbl[i].nm, ".rd_word"},    bus.rd_word,         tbl[i].e_word);
            check({tbl[i].nm, ".fill_level"}, 32'(bus.fill_level), 32'(tbl[i].e_fill));
            check({tbl[i].nm, ".evt_ready"},  32'(bus.evt_ready),  32'(tbl[i].e_ready));
            check({tbl[i].nm, ".ovf_count"},  32'(bus.ovf_count),  32'(tbl[i].e_ovf));
        end

        // drain events 1..4 in order, back-to-back
        for (int e = 1; e <= 4; e++) begin
            r = mk(ev_pps(e), ev_tm(e), ev_d(e));
            for (int j = 0; j < NW; j++) begin
                check($sformatf("drain.e%0d.w%0d", e, j), bus.rd_word, r[j]);
                idle(1'b1);
            end
        end
        check("drain.valid_end", 32'(bus.rd_valid), 32'd0);
        check("drain.fill_end",  32'(bus.fill_level), 32'd0);

        // clear coincident with a drop while full, then a plain clear
        for (int e = 11; e <= 14; e++) push_ev(e, 1'b0, 1'b0);
        push_ev(15, 1'b0, 1'b1);
        check("clr_drop.ovf", 32'(bus.ovf_count), 32'd1);
        step(1'b0, 32'h0, '0, '0, 1'b0, 1'b1, 1'b1);
        check("clr_only.ovf", 32'(bus.ovf_count), 32'd0);

        // push on the cycle the head's last word is acked while full
        for (int j = 0; j < NW - 1; j++) idle(1'b1);
        push_ev(16, 1'b1, 1'b0);
        check("pushpop.ovf",  32'(bus.ovf_count),  32'd1);
        check("pushpop.fill", 32'(bus.fill_level), 32'd3);
        check("pushpop.next_hdr", bus.rd_word, ev_pps(12));
        check("pushpop.next_sof", 32'(bus.rd_sof), 32'd1);
        for (int j = 0; j < 3 * NW; j++) idle(1'b1);
        check("pushpop.fill_end", 32'(bus.fill_level), 32'd0);

        // pointer wrap: write and read ten events one at a time
        step(1'b0, 32'h0, '0, '0, 1'b0, 1'b1, 1'b1);
        for (int e = 20; e < 30; e++) begin
            push_ev(e, 1'b0, 1'b0);
            idle(1'b0);
            r = mk(ev_pps(e), ev_tm(e), ev_d(e));
            for (int j = 0; j < NW; j++) begin
                check($sformatf("wrap.e%0d.w%0d", e, j), bus.rd_word, r[j]);
                check($sformatf("wrap.e%0d.sof%0d", e, j), 32'(bus.rd_sof), 32'(j == 0));
                idle(1'b1);
            end
            check($sformatf("wrap.e%0d.valid_after", e), 32'(bus.rd_valid), 32'd0);
        end
        check("wrap.ovf", 32'(bus.ovf_count), 32'd0);

        // reset part-way through a record with two records stored
        push_ev(30, 1'b0, 1'b0);
        push_ev(31, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) idle(1'b1);
        r = mk(ev_pps(30), ev_tm(30), ev_d(30));
        check("rstmid.w3", bus.rd_word, r[3]);
        step(1'b0, 32'h0, '0, '0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("rstmid.valid", 32'(bus.rd_valid),   32'd0);
        check("rstmid.fill",  32'(bus.fill_level), 32'd0);
        check("rstmid.ready", 32'(bus.evt_ready),  32'd1);
        check("rstmid.ovf",   32'(bus.ovf_count),  32'd0);
        push_ev(32, 1'b0, 1'b0);
        idle(1'b0);
        check("rstmid.new_w0",  bus.rd_word, ev_pps(32));
        check("rstmid.new_sof", 32'(bus.rd_sof), 32'd1);

        // randomized traffic with three write/read balances
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 1500; i++) begin
                bit v, ack, clr, rn;
                int vp, ap;
                vp  = (ph == 0) ? 30 : ((ph == 1) ? 70 : 50);
                ap  = (ph == 0) ? 90 : ((ph == 1) ? 40 : 70);
                v   = ($urandom_range(0, 99) < vp);
                ack = ($urandom_range(0, 99) < ap);
                clr = ($urandom_range(0, 39) == 0);
                rn  = ($urandom_range(0, 299) != 0);
                step(v, $urandom, TIME_W'($urandom), {$urandom, $urandom, $urandom, $urandom},
                     ack, clr, rn);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
